// File: rtl/wb_scheduler_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
//   - write-data mux selector codes
//   - scheduler FSM state encoding
//   - request payload struct (mux code + destination register)
package wb_scheduler_pkg;

    localparam int SEL_W  = 3;
    localparam int ADDR_W = 5;

    typedef enum logic [SEL_W-1:0] {
        SEL_PC       = 3'b000,
        SEL_LT       = 3'b001,
        SEL_CONST227 = 3'b010,
        SEL_LO       = 3'b011,
        SEL_HI       = 3'b100,
        SEL_SHIFT    = 3'b101,
        SEL_ALUOUT   = 3'b110,
        SEL_LOADSZ   = 3'b111
    } wd_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        LOAD_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
    } wb_req_t;

endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// Rotating-priority picker: finds the first set bit of req starting at
// index ptr and wrapping modulo N_REQ.
//   req  - request vector
//   ptr  - index with highest priority this cycle
//   gnt  - one-hot grant (all zero when no request)
//   idx  - binary index of the granted bit
//   any  - at least one request present
module wb_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-back scheduler. Round-robin arbitration of N_REQ
// write requests onto the single register-file write port; load-size
// writes get one extra settle cycle before the write enable pulses.
//   clk, reset_n      - clock, async active-low reset
//   flush             - drop in-flight write, reset round-robin pointer
//   stall             - block new grants (a pending load still completes)
//   req_valid/sel/addr- per-requester request, packed by requester index
//   req_ready         - one-hot combinational grant
//   wd_sel, wr_addr   - registered mux selector and destination register
//   reg_write         - registered write enable
//   busy              - write or load settle in progress
module wb_scheduler
    import wb_scheduler_pkg::*;
#(
    parameter int         N_REQ    = 4,
    parameter logic [2:0] LOAD_SEL = 3'b111
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 stall,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [3*N_REQ-1:0]   req_sel,
    input  logic [5*N_REQ-1:0]   req_addr,
    output logic [N_REQ-1:0]     req_ready,
    output logic [2:0]           wd_sel,
    output logic [4:0]           wr_addr,
    output logic                 reg_write,
    output logic                 busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state, state_n;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_n;
    logic [2:0]       wd_sel_n;
    logic [4:0]       wr_addr_n;
    logic             reg_write_n;

    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             grant_en;
    logic             granted;
    wb_req_t          pick;

    wb_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // reset_n gates the grant so no handshake is offered while in reset.
    assign grant_en  = reset_n && !stall && !flush &&
                       (state == IDLE || state == WRITE);
    assign req_ready = grant_en ? gnt : '0;
    assign granted   = grant_en && gnt_any;
    assign busy      = (state != IDLE);

    always_comb begin
        pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == gnt_idx) begin
                pick.sel  = req_sel[i*3 +: 3];
                pick.addr = req_addr[i*5 +: 5];
            end
        end
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        wd_sel_n    = wd_sel;
        wr_addr_n   = wr_addr;
        reg_write_n = 1'b0;
        if (flush) begin
            state_n  = IDLE;
            rr_ptr_n = '0;
        end else if (granted) begin
            wd_sel_n  = pick.sel;
            wr_addr_n = pick.addr;
            rr_ptr_n  = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
            if (pick.sel == LOAD_SEL) begin
                state_n = LOAD_WAIT;
            end else begin
                state_n     = WRITE;
                // $0 is hardwired: consume the request but never write it.
                reg_write_n = (pick.addr != '0);
            end
        end else begin
            case (state)
                LOAD_WAIT: begin
                    state_n     = WRITE;
                    reg_write_n = (wr_addr != '0);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            wd_sel    <= 3'b000;
            wr_addr   <= '0;
            reg_write <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            wd_sel    <= wd_sel_n;
            wr_addr   <= wr_addr_n;
            reg_write <= reg_write_n;
        end
    end

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler: reset, round-robin rotation, single
// ordinary write, $0 destination, load settle, stall, flush, async reset.
module tb_wb_scheduler;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        stall;
    logic [3:0]  req_valid;
    logic [11:0] req_sel;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [2:0]  wd_sel;
    logic [4:0]  wr_addr;
    logic        reg_write;
    logic        busy;

    int errors = 0;
    int checks = 0;

    wb_scheduler #(.N_REQ(4), .LOAD_SEL(3'b111)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .stall     (stall),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .wd_sel    (wd_sel),
        .wr_addr   (wr_addr),
        .reg_write (reg_write),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] s, input logic [4:0] a);
        req_valid[i]     = v;
        req_sel[i*3 +: 3] = s;
        req_addr[i*5 +: 5] = a;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_addr  = '0;

        // reset with all requesters valid
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'b110, 5'(i + 1));
        tick; tick;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wd_sel", 32'(wd_sel), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_reg_write", 32'(reg_write), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // rotation 0,1,2,3,0
        reset_n = 1'b1;
        #1 chk("rr_ready0", 32'(req_ready), 32'h1);
        tick;
        chk("rr_addr0", 32'(wr_addr), 32'd1);
        chk("rr_we0", 32'(reg_write), 32'h1);
        chk("rr_sel0", 32'(wd_sel), 32'h6);
        chk("rr_ready1", 32'(req_ready), 32'h2);
        tick;
        chk("rr_addr1", 32'(wr_addr), 32'd2);
        chk("rr_we1", 32'(reg_write), 32'h1);
        chk("rr_ready2", 32'(req_ready), 32'h4);
        tick;
        chk("rr_addr2", 32'(wr_addr), 32'd3);
        chk("rr_we2", 32'(reg_write), 32'h1);
        chk("rr_ready3", 32'(req_ready), 32'h8);
        tick;
        chk("rr_addr3", 32'(wr_addr), 32'd4);
        chk("rr_we3", 32'(reg_write), 32'h1);
        chk("rr_ready_wrap", 32'(req_ready), 32'h1);
        tick;
        chk("rr_addr_wrap", 32'(wr_addr), 32'd1);
        req_valid = '0;
        #1 chk("rr_ready_none", 32'(req_ready), 32'h0);
        tick;
        chk("rr_idle_we", 32'(reg_write), 32'h0);
        chk("rr_idle_busy", 32'(busy), 32'h0);
        chk("rr_idle_addr_hold", 32'(wr_addr), 32'd1);

        // single ordinary write: req 2, sel 110, addr 9 (pointer at 1)
        set_req(2, 1'b1, 3'b110, 5'd9);
        #1 chk("one_ready", 32'(req_ready), 32'h4);
        tick;
        chk("one_sel", 32'(wd_sel), 32'h6);
        chk("one_addr", 32'(wr_addr), 32'd9);
        chk("one_we", 32'(reg_write), 32'h1);
        chk("one_busy", 32'(busy), 32'h1);
        set_req(2, 1'b0, 3'b110, 5'd9);
        #1 chk("one_ready_drop", 32'(req_ready), 32'h0);
        tick;
        chk("one_we_end", 32'(reg_write), 32'h0);
        chk("one_busy_end", 32'(busy), 32'h0);
        chk("one_addr_hold", 32'(wr_addr), 32'd9);

        // destination $0 (pointer at 3, wraps to 0)
        set_req(0, 1'b1, 3'b000, 5'd0);
        #1 chk("r0_ready", 32'(req_ready), 32'h1);
        tick;
        chk("r0_sel", 32'(wd_sel), 32'h0);
        chk("r0_addr", 32'(wr_addr), 32'd0);
        chk("r0_we", 32'(reg_write), 32'h0);
        chk("r0_busy", 32'(busy), 32'h1);
        set_req(0, 1'b0, 3'b000, 5'd0);
        tick;
        chk("r0_idle", 32'(busy), 32'h0);

        // load settle: req 1 load to $5, req 3 waiting (pointer at 1)
        set_req(1, 1'b1, 3'b111, 5'd5);
        set_req(3, 1'b1, 3'b110, 5'd7);
        #1 chk("ld_ready", 32'(req_ready), 32'h2);
        tick;
        chk("ld_wait_sel", 32'(wd_sel), 32'h7);
        chk("ld_wait_addr", 32'(wr_addr), 32'd5);
        chk("ld_wait_we", 32'(reg_write), 32'h0);
        chk("ld_wait_busy", 32'(busy), 32'h1);
        set_req(1, 1'b0, 3'b111, 5'd5);
        #1 chk("ld_wait_noready", 32'(req_ready), 32'h0);
        tick;
        chk("ld_we", 32'(reg_write), 32'h1);
        chk("ld_addr", 32'(wr_addr), 32'd5);
        chk("ld_sel", 32'(wd_sel), 32'h7);
        chk("ld_next_ready", 32'(req_ready), 32'h8);
        tick;
        chk("ld_next_sel", 32'(wd_sel), 32'h6);
        chk("ld_next_addr", 32'(wr_addr), 32'd7);
        chk("ld_next_we", 32'(reg_write), 32'h1);
        set_req(3, 1'b0, 3'b110, 5'd7);
        tick;
        chk("ld_idle_we", 32'(reg_write), 32'h0);

        // stall three cycles with 0011 (pointer at 0)
        set_req(0, 1'b1, 3'b001, 5'd10);
        set_req(1, 1'b1, 3'b011, 5'd11);
        stall = 1'b1;
        #1 chk("st_ready", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("st_ready_hold", 32'(req_ready), 32'h0);
            chk("st_we", 32'(reg_write), 32'h0);
        end
        stall = 1'b0;
        #1 chk("st_release_ready", 32'(req_ready), 32'h1);
        tick;
        chk("st_sel", 32'(wd_sel), 32'h1);
        chk("st_addr", 32'(wr_addr), 32'd10);
        chk("st_we1", 32'(reg_write), 32'h1);
        set_req(0, 1'b0, 3'b001, 5'd10);
        #1 chk("st_ready2", 32'(req_ready), 32'h2);
        tick;
        chk("st_sel2", 32'(wd_sel), 32'h3);
        chk("st_addr2", 32'(wr_addr), 32'd11);
        set_req(1, 1'b0, 3'b011, 5'd11);
        tick;
        chk("st_idle", 32'(reg_write), 32'h0);

        // flush during load settle (pointer at 2)
        set_req(2, 1'b1, 3'b111, 5'd12);
        set_req(1, 1'b1, 3'b110, 5'd13);
        #1 chk("fl_ready", 32'(req_ready), 32'h4);
        tick;
        chk("fl_wait_busy", 32'(busy), 32'h1);
        set_req(2, 1'b0, 3'b111, 5'd12);
        flush = 1'b1;
        #1 chk("fl_noready", 32'(req_ready), 32'h0);
        tick;
        chk("fl_we", 32'(reg_write), 32'h0);
        chk("fl_busy", 32'(busy), 32'h0);
        chk("fl_sel_hold", 32'(wd_sel), 32'h7);
        chk("fl_addr_hold", 32'(wr_addr), 32'd12);
        flush = 1'b0;
        set_req(3, 1'b1, 3'b110, 5'd14);
        #1 chk("fl_ptr_reset", 32'(req_ready), 32'h2);
        tick;
        chk("fl_next_addr", 32'(wr_addr), 32'd13);
        chk("fl_next_we", 32'(reg_write), 32'h1);

        // async reset mid-WRITE
        #1 reset_n = 1'b0;
        #1;
        chk("ar_we", 32'(reg_write), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_ready", 32'(req_ready), 32'h0);
        chk("ar_addr", 32'(wr_addr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
